// File: rtl/counter_arbiter_if.sv
// counter_arbiter_if: request/grant bundle between requesters and
// the shared interval counter.
interface counter_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] len;
    logic [NUM_REQ-1:0]            grant;
    logic                          busy;
    logic [DATA_WIDTH-1:0]         count;
    logic [NUM_REQ-1:0]            done;

    modport master (
        output req, len,
        input  grant, busy, count, done
    );

    modport slave (
        input  req, len,
        output grant, busy, count, done
    );
endinterface

// File: rtl/counter_arbiter.sv
// counter_arbiter: round-robin scheduler sharing one interval
// counter among NUM_REQ requesters. All outputs registered.
module counter_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    counter_arbiter_if.slave   bus
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                state, state_d;
    logic [PW-1:0]         ptr, ptr_d;
    logic [PW-1:0]         gidx, gidx_d;
    logic [DATA_WIDTH-1:0] lim, lim_d;
    logic [NUM_REQ-1:0]    grant_q, grant_d;
    logic                  busy_q, busy_d;
    logic [DATA_WIDTH-1:0] count_q, count_d;
    logic [NUM_REQ-1:0]    done_q, done_d;

    logic                  win_found;
    logic [PW-1:0]         win_idx;
    logic [DATA_WIDTH-1:0] win_len;
    logic [PW-1:0]         ptr_inc;

    assign bus.grant = grant_q;
    assign bus.busy  = busy_q;
    assign bus.count = count_q;
    assign bus.done  = done_q;

    assign ptr_inc = (gidx == PW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;

    // Round-robin search starting at ptr, wrapping modulo NUM_REQ.
    always_comb begin
        int idx;
        idx       = 0;
        win_found = 1'b0;
        win_idx   = '0;
        win_len   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!win_found && bus.req[idx]) begin
                win_found = 1'b1;
                win_idx   = PW'(idx);
                win_len   = bus.len[idx*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Next-state and next-output logic for the IDLE/COUNT/DONE machine.
    always_comb begin
        state_d = state;
        ptr_d   = ptr;
        gidx_d  = gidx;
        lim_d   = lim;
        grant_d = grant_q;
        busy_d  = busy_q;
        count_d = count_q;
        done_d  = '0;
        unique case (state)
            IDLE, DONE: begin
                grant_d = '0;
                busy_d  = 1'b0;
                count_d = '0;
                if (win_found) begin
                    state_d          = COUNT;
                    grant_d[win_idx] = 1'b1;
                    busy_d           = 1'b1;
                    gidx_d           = win_idx;
                    lim_d            = (win_len == '0) ?
                                       DATA_WIDTH'(1) : win_len;
                end else begin
                    state_d = IDLE;
                end
            end
            COUNT: begin
                if (bus.req[gidx]) begin
                    if (count_q == lim - 1'b1) begin
                        state_d      = DONE;
                        grant_d      = '0;
                        busy_d       = 1'b0;
                        count_d      = '0;
                        done_d[gidx] = 1'b1;
                        ptr_d        = ptr_inc;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end else begin
                    // Abort: requester withdrew mid-interval.
                    state_d = IDLE;
                    grant_d = '0;
                    busy_d  = 1'b0;
                    count_d = '0;
                    ptr_d   = ptr_inc;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
                count_d = '0;
            end
        endcase
    end

    // State and registered outputs; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            ptr     <= '0;
            gidx    <= '0;
            lim     <= '0;
            grant_q <= '0;
            busy_q  <= 1'b0;
            count_q <= '0;
            done_q  <= '0;
        end else begin
            state   <= state_d;
            ptr     <= ptr_d;
            gidx    <= gidx_d;
            lim     <= lim_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: tb/tb_counter_arbiter.sv
// tb_counter_arbiter: directed checks of the round-robin
// interval counter arbiter.
module tb_counter_arbiter;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    counter_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(8)) bus ();

    counter_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic setlen(input int i, input logic [7:0] v);
        bus.len[i*8 +: 8] = v;
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        rst     = 1'b0;
        bus.req = '0;
        bus.len = '0;
        step();
        step();
        chk("rst_grant", 32'(bus.grant), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_count", 32'(bus.count), 32'h0);
        chk("rst_done", 32'(bus.done), 32'h0);
        chk("rst_ptr", 32'(dut.ptr), 32'h0);
        rst = 1'b1;

        // single requester, len 3
        bus.req = 4'b0100;
        setlen(2, 8'd3);
        for (int c = 0; c < 3; c++) begin
            step();
            chk("single_grant", 32'(bus.grant), 32'h4);
            chk("single_busy", 32'(bus.busy), 32'h1);
            chk("single_count", 32'(bus.count), 32'(c));
        end
        step();
        chk("single_done", 32'(bus.done), 32'h4);
        chk("single_grant_off", 32'(bus.grant), 32'h0);
        bus.req = '0;
        step();
        chk("single_idle_busy", 32'(bus.busy), 32'h0);
        chk("single_idle_done", 32'(bus.done), 32'h0);
        chk("single_ptr", 32'(dut.ptr), 32'h3);

        // simultaneous requests from a fresh reset
        rst = 1'b0;
        step();
        rst = 1'b1;
        bus.req = 4'b1111;
        for (int i = 0; i < 4; i++) setlen(i, 8'd2);
        for (int r = 0; r < 4; r++) begin
            step();
            chk("rr_grant0", 32'(bus.grant), 32'(1 << r));
            chk("rr_count0", 32'(bus.count), 32'h0);
            step();
            chk("rr_grant1", 32'(bus.grant), 32'(1 << r));
            chk("rr_count1", 32'(bus.count), 32'h1);
            step();
            chk("rr_done", 32'(bus.done), 32'(1 << r));
            chk("rr_gap", 32'(bus.grant), 32'h0);
            bus.req[r] = 1'b0;
        end
        step();
        chk("rr_idle", 32'(bus.busy), 32'h0);
        chk("rr_ptr", 32'(dut.ptr), 32'h0);

        // fairness: two requesters held high, len 1
        bus.req = 4'b0011;
        for (int i = 0; i < 4; i++) setlen(i, 8'd1);
        for (int r = 0; r < 4; r++) begin
            step();
            chk("fair_grant", 32'(bus.grant), 32'(1 << (r % 2)));
            step();
            chk("fair_done", 32'(bus.done), 32'(1 << (r % 2)));
        end
        bus.req = '0;
        step();
        chk("fair_idle", 32'(bus.grant), 32'h0);

        // abort at count 4
        bus.req = 4'b0010;
        setlen(1, 8'd10);
        step();
        chk("abort_grant", 32'(bus.grant), 32'h2);
        for (int c = 0; c < 4; c++) step();
        chk("abort_count4", 32'(bus.count), 32'h4);
        setlen(1, 8'd2);
        bus.req = '0;
        step();
        chk("abort_grant0", 32'(bus.grant), 32'h0);
        chk("abort_count0", 32'(bus.count), 32'h0);
        chk("abort_done", 32'(bus.done), 32'h0);
        chk("abort_ptr", 32'(dut.ptr), 32'h2);
        step();
        chk("abort_nodone", 32'(bus.done), 32'h0);

        // len 0 acts as 1
        bus.req = 4'b0100;
        setlen(2, 8'd0);
        step();
        chk("len0_grant", 32'(bus.grant), 32'h4);
        step();
        chk("len0_grant_off", 32'(bus.grant), 32'h0);
        chk("len0_done", 32'(bus.done), 32'h4);
        bus.req = '0;
        step();
        chk("len0_ptr", 32'(dut.ptr), 32'h3);

        // len 255: count reaches 254, no wrap
        bus.req = 4'b1000;
        setlen(3, 8'd255);
        step();
        chk("max_grant", 32'(bus.grant), 32'h8);
        chk("max_count0", 32'(bus.count), 32'h0);
        for (int c = 0; c < 253; c++) step();
        chk("max_count253", 32'(bus.count), 32'd253);
        step();
        chk("max_count254", 32'(bus.count), 32'd254);
        chk("max_grant_last", 32'(bus.grant), 32'h8);
        step();
        chk("max_done", 32'(bus.done), 32'h8);
        chk("max_count_clr", 32'(bus.count), 32'h0);
        bus.req = '0;
        step();
        chk("max_ptr", 32'(dut.ptr), 32'h0);

        // reset mid-count
        bus.req = 4'b0001;
        setlen(0, 8'd20);
        step();
        for (int c = 0; c < 5; c++) step();
        chk("mid_count5", 32'(bus.count), 32'h5);
        rst = 1'b0;
        step();
        chk("mid_rst_grant", 32'(bus.grant), 32'h0);
        chk("mid_rst_count", 32'(bus.count), 32'h0);
        chk("mid_rst_busy", 32'(bus.busy), 32'h0);
        chk("mid_rst_done", 32'(bus.done), 32'h0);
        rst = 1'b1;
        bus.req = 4'b0110;
        step();
        chk("post_rst_grant", 32'(bus.grant), 32'h2);
        step();
        chk("post_rst_nodone", 32'(bus.done), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/counter_arbiter.md
# counter_arbiter

Round-robin scheduler that shares one interval counter among `NUM_REQ` requesters. Each requester presents a request and an interval length. The block grants the counter to one requester at a time, counts out that requester's interval, and then pulses that requester's done line. It sits in front of timed datapath users (strobes, gated windows, pacing logic) that would otherwise each need a private counter instance.

## Interface
- `NUM_REQ`, default 4: number of requesters, valid range 2..16.
- `DATA_WIDTH`, default 8: width of interval lengths and of the count output.

- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-low reset. It is sampled on the rising edge of `clk`.
- `req`  in  NUM_REQ  per-requester request level. Bit i belongs to requester i.
- `len`  in  NUM_REQ*DATA_WIDTH  packed interval lengths. Requester i uses bits [i*DATA_WIDTH +: DATA_WIDTH].
- `grant`  out  NUM_REQ  one-hot grant, or all zeros when idle.
- `busy`  out  1  high while any grant is active.
- `count`  out  DATA_WIDTH  current position within the granted interval.
- `done`  out  NUM_REQ  one-cycle pulse on the requester whose interval completed.

## Operation
- State machine with three states: IDLE, COUNT, DONE.
- Reset (`rst`=0 at an edge) forces:
  - state IDLE;
  - `grant`=0, `busy`=0, `count`=0, `done`=0;
  - priority pointer `ptr`=0, so requester 0 has highest priority.
- Arbitration happens in IDLE and in DONE:
  - The winner is the first i with `req[i]`=1, searching i = ptr, ptr+1, … with wrap modulo NUM_REQ.
  - On the winner, the next state is COUNT.
  - `grant` becomes one-hot on the winner, `busy`=1 and `count`=0.
  - The winner's `len` is latched as L. A latched `len` of 0 is treated as L=1.
- COUNT:
  - `len` is not re-sampled; changes during COUNT have no effect.
  - If the granted requester's `req` is still high and `count` < L-1, `count` increments by 1.
  - If the granted requester's `req` is still high and `count` == L-1, the next state is DONE. On entry to DONE: `grant`=0, `busy`=0, `count`=0, `done[i]`=1, and `ptr` = (i+1) mod NUM_REQ.
  - If the granted requester drops `req`, this is an abort. The next state is IDLE: `grant`=0, `busy`=0, `count`=0, no `done` pulse, and `ptr` = (i+1) mod NUM_REQ.
- DONE:
  - Lasts exactly one cycle; `done` clears on exit.
  - Arbitration runs in the same cycle, so a pending request is granted on the following cycle. Otherwise the next state is IDLE.
- Requesters must drop `req` in the cycle `done` is seen. A `req` still high is treated as a new request, subject to round-robin order.
- Requests from non-granted requesters are held off and never dropped by the block.
- `count` never wraps: the maximum value is 2^DATA_WIDTH-2, reached when L = 2^DATA_WIDTH-1.

## Timing
- Request-to-grant latency is 1 cycle. If `req[i]` is high at edge E in IDLE, `grant[i]` is high from E.
- With L cycles, `grant` is high for exactly L cycles, and `count` shows 0,1,…,L-1.
- `done` is high for the single cycle after the last granted cycle.
- Back-to-back grants: the earliest next grant starts 1 cycle after `done`, so there is one idle gap cycle per interval.
- Reset takes priority over every other event, including mid-COUNT and the DONE cycle. The reset response is visible in the cycle after the sampling edge. An in-progress interval is discarded with no `done` pulse.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Single requester, NUM_REQ=4:
  - Stimulus: `req[2]`=1 with `len`=3.
  - Required: `grant`=0100 for 3 cycles; `count` shows 0,1,2; `done[2]` pulses in the next cycle.
  - Then drop `req`: `busy`=0 and `ptr`=3.
- Simultaneous requests:
  - Stimulus: `req`=1111, all `len`=2, each requester dropping its `req` on its `done`.
  - Required grant order: 0,1,2,3, each lasting 2 cycles, separated by single DONE cycles.
- Fairness:
  - Stimulus: `req[0]` and `req[1]` held permanently high, `len`=1.
  - Required: grants alternate 0,1,0,1.
- Abort:
  - Stimulus: `req[1]`=1 with `len`=10, then drop `req[1]` when `count`=4.
  - Required: `grant`=0 and `count`=0 on the next cycle; no `done`; `ptr`=2.
- Length zero and maximum:
  - `len`=0 → `grant` high for exactly 1 cycle, then `done`.
  - `len`=255 → 255 grant cycles with final `count`=254 and no wrap.
- Reset mid-operation:
  - Stimulus: `rst`=0 while `count`=5.
  - Required: all outputs are 0 on the next cycle.
  - After reset releases with `req`=0110, requester 1 is granted first.
